// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared constants, parity-check rows and FSM encoding for the (15,7) EG-LDPC blocks
package ldpc_pkg;
  localparam int N = 15;
  localparam int K = 7;
  localparam int D_HI = 14;
  localparam int D_LO = 8;
  localparam logic [N-1:0] H_ROW0 = 15'h008B;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ITER = 2'd1;
  localparam state_t S_DONE = 2'd2;
  function automatic logic [N-1:0] h_row(input int r);
    return (H_ROW0 << r) | (H_ROW0 >> (N - r));
  endfunction
  function automatic logic h_bit(input int r, input int j);
    logic [N-1:0] row;
    row = h_row(r);
    return row[j];
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v + 16'(v != 16'hFFFF);
  endfunction
endpackage

// File: rtl/ldpc_syndrome.sv
// ldpc_syndrome: combinational syndrome and per-bit unsatisfied-check counts
// Ports: i_cw codeword in; o_s syndrome bits; o_u per-bit count of set checks (0..4).
module ldpc_syndrome
  import ldpc_pkg::*;
(
  input  logic [N-1:0]      i_cw,
  output logic [N-1:0]      o_s,
  output logic [N-1:0][2:0] o_u
);
  always_comb begin
    o_s = '0;
    o_u = '0;
    for (int r = 0; r < N; r++) o_s[r] = ^(i_cw & h_row(r));
    for (int j = 0; j < N; j++)
      for (int r = 0; r < N; r++) o_u[j] = o_u[j] + 3'(h_bit(r, j) & o_s[r]);
  end
endmodule

// File: rtl/ldpc_corrector.sv
// ldpc_corrector: iterative bit-flipping corrector for the (15,7) EG-LDPC code
// Ports: clk/rst_n; i_in_valid/o_in_ready/i_c_in input handshake; o_out_valid/i_out_ready
// output handshake with o_c_out, o_d_out, o_iters, o_corrected, o_fail.
// Optional CORR_STATS_EN adds i_stat_clr and saturating o_stat_words/o_stat_corr/o_stat_fail.
module ldpc_corrector
  import ldpc_pkg::*;
#(
  parameter int MAX_ITER = 4,
  parameter int THRESH   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef CORR_STATS_EN
  input  logic                         i_stat_clr,
  output logic [15:0]                  o_stat_words,
  output logic [15:0]                  o_stat_corr,
  output logic [15:0]                  o_stat_fail,
`endif
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [N-1:0]                 i_c_in,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [N-1:0]                 o_c_out,
  output logic [K-1:0]                 o_d_out,
  output logic [$clog2(MAX_ITER+1)-1:0] o_iters,
  output logic                         o_corrected,
  output logic                         o_fail
);
  localparam int IW = $clog2(MAX_ITER + 1);
  state_t              r_state;
  logic [N-1:0]        r_cw;
  logic [IW-1:0]       r_itc;
  logic                r_corr, r_fail;
  logic [N-1:0]        w_s, w_flip;
  logic [N-1:0][2:0]   w_u;
  logic                w_acc, w_hs;
  ldpc_syndrome u_syn (.i_cw(r_cw), .o_s(w_s), .o_u(w_u));
  always_comb begin
    w_flip = '0;
    for (int j = 0; j < N; j++) w_flip[j] = w_u[j] >= 3'(THRESH);
  end
  assign w_acc = i_in_valid && r_state == S_IDLE;
  assign w_hs  = i_out_ready && r_state == S_DONE;
  // A nonzero syndrome with nothing reaching THRESH can never make progress, so it fails at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cw    <= '0;
      r_itc   <= '0;
      r_corr  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (w_acc) begin
      r_state <= S_ITER;
      r_cw    <= i_c_in;
      r_itc   <= '0;
      r_corr  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (r_state == S_ITER) begin
      if (w_s == '0) begin
        r_state <= S_DONE;
        r_corr  <= r_itc != '0;
      end else if (r_itc == IW'(MAX_ITER) || w_flip == '0) begin
        r_state <= S_DONE;
        r_fail  <= 1'b1;
      end else begin
        r_cw  <= r_cw ^ w_flip;
        r_itc <= r_itc + 1'b1;
      end
    end else if (w_hs) begin
      r_state <= S_IDLE;
    end
  end
`ifdef CORR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_words <= '0;
      o_stat_corr  <= '0;
      o_stat_fail  <= '0;
    end else if (i_stat_clr) begin
      o_stat_words <= '0;
      o_stat_corr  <= '0;
      o_stat_fail  <= '0;
    end else if (w_hs) begin
      o_stat_words <= sat_inc(o_stat_words);
      o_stat_corr  <= r_corr ? sat_inc(o_stat_corr) : o_stat_corr;
      o_stat_fail  <= r_fail ? sat_inc(o_stat_fail) : o_stat_fail;
    end
  end
`endif
  assign o_in_ready  = r_state == S_IDLE;
  assign o_out_valid = r_state == S_DONE;
  assign o_c_out     = r_cw;
  assign o_d_out     = r_cw[D_HI:D_LO];
  assign o_iters     = r_itc;
  assign o_corrected = r_corr;
  assign o_fail      = r_fail;
endmodule
